// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants, the scan coordinate type and the scan FSM
// state encoding used by the timing generator and the pixel address logic.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  localparam int COORD_W     = 10;
  localparam int COORD_LIMIT = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_t;

  // Half-open window test, done in 32 bits so an end bound of COORD_LIMIT cannot wrap.
  function automatic logic in_window(coord_t c, int lo, int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_scan_generator_if.sv
// Scan bundle from the timing generator to the pixel pipeline and DAC.
interface vga_scan_generator_if;
  import vga_pkg::*;

  // No back-pressure: pix_en acts as the valid qualifier for x_pixel/y_pixel and the
  // strobes; the consumer must take every tick, there is no ready.
  logic        pix_en;
  coord_t      x_pixel;
  coord_t      y_pixel;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        hsync_d;
  logic        vsync_d;
  logic        video_on_d;
  logic        line_start;
  logic        frame_start;
  scan_state_t scan_state;

  modport master (
    output pix_en, x_pixel, y_pixel, video_on, hsync, vsync,
           hsync_d, vsync_d, video_on_d, line_start, frame_start, scan_state
  );

  modport slave (
    input pix_en, x_pixel, y_pixel, video_on, hsync, vsync,
          hsync_d, vsync_d, video_on_d, line_start, frame_start, scan_state
  );

endinterface

// File: rtl/sync_delay_line.sv
// Shift register advanced on a strobe, with synchronous flush to a reset pattern.
// DEPTH=0 degenerates to a plain wire.
module sync_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = &{1'b0, clk, rst_n, flush, shift_en};
    assign q      = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else if (flush) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else if (shift_en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_generator.sv
// Raster timing generator: pixel tick from the system clock, h/v scan counters,
// sync/blank decode and a latency-matched copy of sync/blank for the DAC.
module vga_scan_generator
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int SYNC_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  vga_scan_generator_if.master  scan
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam coord_t            H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t            V_LAST   = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT || CLK_DIV < 1) begin : g_bad_params
    $error("vga_scan_generator: timing does not fit 10-bit counters or CLK_DIV < 1");
  end

  scan_state_t      state, state_next;
  logic [DIV_W-1:0] div_cnt;
  coord_t           h_cnt;
  coord_t           v_cnt;
  logic             running;
  logic             pix_en;
  logic             video_c;
  logic             hsync_c;
  logic             vsync_c;
  logic [2:0]       delayed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) state_next = ST_IDLE;
    else         state_next = ST_RUN;
  end

  assign running = (state == ST_RUN);
  assign pix_en  = running && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (running) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
        end else begin
          h_cnt <= h_cnt + coord_t'(1);
        end
      end
    end
  end

  // Counters are already zero whenever running is low; the gating keeps the
  // sync/blank decode at idle levels during the first edge after enable.
  assign video_c = running && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hsync_c = ~(running && in_window(h_cnt, HS_START, HS_END));
  assign vsync_c = ~(running && in_window(v_cnt, VS_START, VS_END));

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (3'b110)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (!enable),
    .shift_en (pix_en),
    .d        ({hsync_c, vsync_c, video_c}),
    .q        (delayed)
  );

  assign scan.pix_en      = pix_en;
  assign scan.x_pixel     = running ? h_cnt : '0;
  assign scan.y_pixel     = running ? v_cnt : '0;
  assign scan.video_on    = video_c;
  assign scan.hsync       = hsync_c;
  assign scan.vsync       = vsync_c;
  assign scan.hsync_d     = delayed[2];
  assign scan.vsync_d     = delayed[1];
  assign scan.video_on_d  = delayed[0];
  assign scan.line_start  = pix_en && (h_cnt == '0);
  assign scan.frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
  assign scan.scan_state  = state;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: two shrunken rasters (delay 2 / div 2 and delay 0 /
// div 1) plus the full 640x480 raster, all compared every clock against a model.
module tb_vga_scan_generator;
  import vga_pkg::*;

  localparam int W = 29;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  always #5 clk = ~clk;

  vga_scan_generator_if s2();
  vga_scan_generator_if s0();
  vga_scan_generator_if sf();

  vga_scan_generator #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(2)
  ) dut_small (.clk(clk), .rst_n(rst_n), .enable(enable), .scan(s2));

  vga_scan_generator #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(0)
  ) dut_pass (.clk(clk), .rst_n(rst_n), .enable(enable), .scan(s0));

  vga_scan_generator dut_full (.clk(clk), .rst_n(rst_n), .enable(enable), .scan(sf));

  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp0_q [$];
  logic [W-1:0] expf_q [$];

  int n_cmp = 0;
  int n_err = 0;
  bit m_run = 0;
  int m_t   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {hsync_n, vsync_n, video_on} for global pixel index p of a raster
  function automatic logic [2:0] decode(int p, int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb);
    int ht, vt, x, y;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    x  = p % ht;
    y  = (p / ht) % vt;
    return {!(x >= ha + hf && x < ha + hf + hs),
            !(y >= va + vf && y < va + vf + vs),
            (x < ha && y < va)};
  endfunction

  function automatic logic [W-1:0] model_out(bit run, int t, int cdiv, int ha, int hf,
                                             int hs, int hb, int va, int vf, int vs,
                                             int vb, int dly);
    int p, ht, vt;
    logic pe;
    logic [9:0] x, y;
    logic [2:0] cur, del;
    if (!run) return {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    p   = t / cdiv;
    pe  = (t % cdiv) == cdiv - 1;
    x   = 10'(p % ht);
    y   = 10'((p / ht) % vt);
    cur = decode(p, ha, hf, hs, hb, va, vf, vs, vb);
    del = (p >= dly) ? decode(p - dly, ha, hf, hs, hb, va, vf, vs, vb) : 3'b110;
    return {pe, x, y, cur[0], cur[2], cur[1], del[2], del[1], del[0],
            pe && x == 0, pe && x == 0 && y == 0};
  endfunction

  task automatic drive_cycle(input logic en);
    enable = en;
    @(posedge clk);
    if (!rst_n || !enable) m_run = 0;
    else if (!m_run) begin
      m_run = 1;
      m_t   = 0;
    end else m_t++;
    exp_q.push_back(model_out(m_run, m_t, 2, 8, 2, 3, 2, 6, 1, 2, 1, 2));
    exp0_q.push_back(model_out(m_run, m_t, 1, 8, 2, 3, 2, 6, 1, 2, 1, 0));
    expf_q.push_back(model_out(m_run, m_t, 2, 640, 16, 96, 48, 480, 10, 2, 33, 2));
    @(negedge clk);
    if (exp_q.size() == 0 || exp0_q.size() == 0 || expf_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      check("scan_small", 32'({s2.pix_en, s2.x_pixel, s2.y_pixel, s2.video_on, s2.hsync,
            s2.vsync, s2.hsync_d, s2.vsync_d, s2.video_on_d, s2.line_start,
            s2.frame_start}), 32'(exp_q.pop_front()));
      check("scan_pass", 32'({s0.pix_en, s0.x_pixel, s0.y_pixel, s0.video_on, s0.hsync,
            s0.vsync, s0.hsync_d, s0.vsync_d, s0.video_on_d, s0.line_start,
            s0.frame_start}), 32'(exp0_q.pop_front()));
      check("scan_full", 32'({sf.pix_en, sf.x_pixel, sf.y_pixel, sf.video_on, sf.hsync,
            sf.vsync, sf.hsync_d, sf.vsync_d, sf.video_on_d, sf.line_start,
            sf.frame_start}), 32'(expf_q.pop_front()));
    end
  endtask

  initial begin
    int vid_clks, hs_clks, d0_diff, hsd_x;
    int ls_a, ls_b, fs_a, fs_b, f0_a, f0_b, vr, vdr;

    rst_n  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0);
    check("rst_state", 32'(s2.scan_state), 32'(ST_IDLE));
    check("rst_sync", 32'({sf.hsync, sf.vsync, sf.hsync_d, sf.vsync_d, sf.video_on_d}),
          32'b11110);

    // Release straight into a run; first pixel tick lands two clocks in
    rst_n = 1'b1;
    drive_cycle(1'b1);
    check("first_tick_early", 32'(s2.pix_en), 32'd0);
    drive_cycle(1'b1);
    check("first_tick", 32'(s2.pix_en), 32'd1);
    for (int i = 0; i < 599; i++) drive_cycle(1'b1);
    check("midline_x", 32'(sf.x_pixel), 32'd300);

    // Asynchronous reset mid-line must idle the outputs without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_xy", 32'({sf.x_pixel, sf.y_pixel}), 32'd0);
    check("async_rst_out", 32'({sf.pix_en, sf.video_on, sf.hsync, sf.vsync}), 32'b0011);
    drive_cycle(1'b1);
    drive_cycle(1'b1);
    rst_n = 1'b1;

    vid_clks = 0; hs_clks = 0; d0_diff = 0; hsd_x = -1;
    ls_a = -1; ls_b = -1; fs_a = -1; fs_b = -1; f0_a = -1; f0_b = -1; vr = -1; vdr = -1;
    for (int i = 0; i < 1700; i++) begin
      drive_cycle(1'b1);
      if (i < 1600) begin
        if (sf.video_on) vid_clks++;
        if (!sf.hsync) hs_clks++;
      end
      if (sf.line_start)  begin if (ls_a < 0) ls_a = i; else if (ls_b < 0) ls_b = i; end
      if (s2.frame_start) begin if (fs_a < 0) fs_a = i; else if (fs_b < 0) fs_b = i; end
      if (s0.frame_start) begin if (f0_a < 0) f0_a = i; else if (f0_b < 0) f0_b = i; end
      if (s2.video_on && vr < 0) vr = i;
      if (s2.video_on_d && vdr < 0) vdr = i;
      if (!sf.hsync_d && hsd_x < 0) hsd_x = int'(sf.x_pixel);
      if ({s0.hsync_d, s0.vsync_d, s0.video_on_d} !== {s0.hsync, s0.vsync, s0.video_on})
        d0_diff++;
    end
    check("line_video_clks", 32'(vid_clks), 32'd1280);
    check("line_hsync_clks", 32'(hs_clks), 32'd192);
    check("line_period", 32'(ls_b - ls_a), 32'd1600);
    check("frame_period_small", 32'(fs_b - fs_a), 32'd300);
    check("frame_period_pass", 32'(f0_b - f0_a), 32'd150);
    check("video_d_lag", 32'(vdr - vr), 32'd4);
    check("hsync_d_x", 32'(hsd_x), 32'd658);
    check("delay0_equal", 32'(d0_diff), 32'd0);

    // Enable drop: next edge idles everything and flushes the delay lines
    for (int i = 0; i < int'($urandom_range(1, 40)); i++) drive_cycle(1'b1);
    drive_cycle(1'b0);
    check("disable_idle", 32'({s2.pix_en, s2.x_pixel, s2.y_pixel, s2.hsync_d, s2.vsync_d,
          s2.video_on_d}), 32'b110);
    drive_cycle(1'b1);
    check("restart_pass_frame", 32'(s0.frame_start), 32'd1);
    drive_cycle(1'b1);
    check("restart_frame", 32'(s2.frame_start), 32'd1);

    for (int i = 0; i < 400; i++) drive_cycle(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0);

    check("queue_drain", 32'(exp_q.size() + exp0_q.size() + expf_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_scan_generator.md
Name: vga_scan_generator

Overview:
- Raster timing generator for the 640x480@60 Hz display path; drives the x_pixel/y_pixel scan coordinates consumed by pixel_address, plus sync/blanking to the DAC.
- Produces a pixel-rate tick from the system clock.
- Provides delayed sync/blank copies aligned to the downstream address-to-memory-to-colour latency.

Parameters:
- CLK_DIV, 2, system clocks per pixel (2 gives 25 MHz from 50 MHz); >=1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 2, pixel ticks of delay on the *_d outputs; 0 = passthrough

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan run control
- pix_en  out  1  one-clk pixel tick
- x_pixel  out  10  horizontal count, 0..H_TOTAL-1
- y_pixel  out  10  vertical count, 0..V_TOTAL-1
- video_on  out  1  current (x,y) inside the active area
- hsync  out  1  active-low horizontal sync, undelayed
- vsync  out  1  active-low vertical sync, undelayed
- hsync_d  out  1  hsync delayed by SYNC_DELAY ticks
- vsync_d  out  1  vsync delayed by SYNC_DELAY ticks
- video_on_d  out  1  video_on delayed by SYNC_DELAY ticks
- line_start  out  1  strobe: pix_en while x_pixel==0
- frame_start  out  1  strobe: pix_en while x_pixel==0 and y_pixel==0

Behaviour:
- H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- State registers:
  - running flag
  - div counter, 0..CLK_DIV-1
  - h_cnt
  - v_cnt
- Reset (async, rst_n=0):
  - running=0, div=0, h_cnt=0, v_cnt=0.
  - Outputs: pix_en=0, x_pixel=0, y_pixel=0, video_on=0, hsync=vsync=1, all *_d at idle (1,1,0), strobes 0.
- enable low (sampled at clk):
  - Next edge: running=0 and div/h_cnt/v_cnt are cleared; outputs return to idle values.
  - Delay lines are flushed to idle.
- enable high:
  - running=1 on the first edge.
  - div increments each clk and wraps at CLK_DIV-1.
  - pix_en = running && div==CLK_DIV-1, which is combinational from registers. Each coordinate is held for exactly CLK_DIV clocks.
- On pix_en:
  - h_cnt increments; h_cnt wraps at H_TOTAL-1 to 0 and increments v_cnt.
  - v_cnt wraps at V_TOTAL-1 to 0 on the same tick as the h wrap.
- Outputs are combinational decode of the registers, all gated by running:
  - x_pixel=h_cnt, y_pixel=v_cnt.
  - video_on = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync low iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync low iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Delay line:
  - SYNC_DELAY-deep shift register of {hsync, vsync, video_on}, advanced only on pix_en.
  - Shift register reset/flush value is {1,1,0}.
- Simultaneous h-wrap and v-wrap on one tick: both counters go to 0 and frame_start fires on the following tick (the first tick of pixel (0,0)).
- CLK_DIV=1: pix_en is constantly high while running.
- Width rule: 10-bit counters; parameter sets with H_TOTAL or V_TOTAL > 1024 are illegal and must be rejected by an elaboration assertion.

Decomposition:
- Package vga_pkg:
  - 640x480 timing constants.
  - Derived H_TOTAL, V_TOTAL, HS_START/HS_END, VS_START/VS_END.
  - The 10-bit coord_t typedef, shared with pixel_address.
- Sub-module sync_delay_line:
  - Parameters WIDTH, DEPTH, RESET_VAL.
  - Inputs clk, rst_n, flush, shift_en, d; output q.
  - DEPTH=0 is a wire passthrough.

Test Plan:
- Reset/idle: assert rst_n=0 mid-line (h_cnt=300) -> immediately x=y=0, hsync=vsync=1, video_on=0, pix_en=0; release with enable=1 -> pix_en first high 2 clks later; x advances 0,1,2 every 2 clks.
- Horizontal timing: run one line -> video_on high exactly 640 ticks (1280 clks); hsync low for x=656..751 (192 clks); line_start period 1600 clks.
- Vertical timing and wrap: run full frame -> vsync low for y=490..491 (3200 clks); (799,524) followed by (0,0) with frame_start; frame_start period 840000 clks; y never exceeds 524.
- Delay alignment (SYNC_DELAY=2): video_on_d rises exactly 2 pix_en ticks after video_on; hsync_d falls when x=658; with SYNC_DELAY=0, *_d equal undelayed signals every clk.
- Enable toggle: drop enable at (400,200) -> next clk all outputs idle and delay lines flushed; re-enable -> scan restarts at (0,0) with frame_start on its first pix_en.
- Downstream hookup: drive pixel_address from x_pixel/y_pixel for a frame -> no X on address; in_region only asserted while video_on=1.
